muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64, even.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports CLK and nRST.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled on the CLK rising edge.
REQ-006 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 portA  input  WIDTH  multiplicand or dividend.
REQ-008 portB  input  WIDTH  multiplier or divisor.
REQ-009 busy  output  1  operation in progress; start is ignored.
REQ-010 done  output  1  one-cycle pulse: hi, lo and div_by_zero are updated.
REQ-011 hi  output  WIDTH  product upper half, or remainder.
REQ-012 lo  output  WIDTH  product lower half, or quotient.
REQ-013 div_by_zero  output  1  last completed operation was a DIV or DIVU with portB == 0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; busy = (state == CALC), and done = (state == DONE).
REQ-015 In IDLE or DONE, start = 1 SHALL latch op, portA and portB on that edge and enter CALC with an iteration counter of 0; otherwise DONE returns to IDLE.
REQ-016 In CALC, start SHALL be ignored, and operand inputs may change without effect.
REQ-017 CALC SHALL perform exactly one iteration per cycle for WIDTH cycles (shift-add for multiply, restoring shift-subtract for divide), then enter DONE.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high during the cycle following edge N+WIDTH+1 (WIDTH+1 cycles after acceptance).
REQ-019 hi, lo and div_by_zero SHALL be written only on the edge entering DONE, and SHALL hold their values until the next completion.
REQ-020 Signed ops SHALL take magnitudes of the operands, compute unsigned, then negate the 2*WIDTH-bit product if the operand signs differ.
REQ-021 For signed division, the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend (truncation toward zero).
REQ-022 Signed division of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag raised.
REQ-023 DIV or DIVU with portB == 0 SHALL skip CALC and enter DONE on the next edge, with lo = all ones, hi = portA, and div_by_zero = 1.
REQ-024 All other completions SHALL clear div_by_zero.
REQ-025 Multiply results SHALL be exact in 2*WIDTH bits (hi:lo); no overflow output exists.
REQ-026 When start is asserted in the DONE cycle, the new operation SHALL begin back-to-back, with no IDLE cycle inserted.

Reset
REQ-027 On nRST low, at any time including mid-CALC, the block SHALL immediately force state = IDLE, counter = 0, busy = 0, done = 0, hi = 0, lo = 0 and div_by_zero = 0.
REQ-028 On nRST low, any in-flight operation SHALL be discarded.
REQ-029 After nRST deasserts, the first rising edge SHALL accept start normally.

Verification (WIDTH = 32)
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after start; hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-031 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
REQ-033 DIVU 100 / 0 -> done 1 cycle after start; lo = 0xFFFFFFFF, hi = 0x00000064, div_by_zero = 1; a following MULTU 2 x 3 -> lo = 6, hi = 0, div_by_zero = 0.
REQ-034 start pulsed at cycles 5 and 10 of a CALC -> only one done pulse occurs, and the result is that of the first operands; a start asserted in the DONE cycle -> busy = 1 on the next cycle.
REQ-035 nRST asserted at CALC cycle 16 -> busy, done, hi, lo and div_by_zero all 0 immediately; no done pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit.
// Performs one shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle on operand magnitudes, then applies sign fix-ups on the final
// CALC cycle. Division by zero bypasses CALC and completes immediately.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_q;      // running upper product half or partial remainder
  logic [WIDTH-1:0]   q_q;        // multiplier bits shifting out, or quotient shifting in
  logic               res_neg_q;  // product / quotient must be negated
  logic               rem_neg_q;  // remainder takes the dividend's sign

  // Operand sign handling: op[0] = 0 selects the signed variants.
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg    = ~op[0] & portA[WIDTH-1];
  assign b_neg    = ~op[0] & portB[WIDTH-1];
  assign a_mag    = a_neg ? -portA : portA;
  assign b_mag    = b_neg ? -portB : portB;
  assign div_zero = op[1] && (portB == '0);

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // One iteration of the selected algorithm on the current partial state.
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] acc_nx, q_nx;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    add_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, q_q[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd_q};
    diff    = shifted - {1'b0, opnd_q};
    if (op_q[1]) begin
      acc_nx = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      q_nx   = {q_q[WIDTH-2:0], fits};
    end else begin
      acc_nx = add_sum[WIDTH:1];
      q_nx   = {add_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the finished magnitudes into the architectural result.
  logic [2*WIDTH-1:0] product, product_f;
  logic [WIDTH-1:0]   quot_f, rem_f, hi_f, lo_f;

  always_comb begin
    product   = {acc_q, q_q};
    product_f = res_neg_q ? -product : product;
    quot_f    = res_neg_q ? -q_q : q_q;
    rem_f     = rem_neg_q ? -acc_q : acc_q;
    if (op_q[1]) begin
      hi_f = rem_f;
      lo_f = quot_f;
    end else begin
      hi_f = product_f[2*WIDTH-1:WIDTH];
      lo_f = product_f[WIDTH-1:0];
    end
  end

  // Control FSM together with the datapath and result registers.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    if (!nRST) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q      <= op;
            count     <= '0;
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            acc_q     <= '0;
            // Divide: q holds the dividend; multiply: q holds the multiplier.
            q_q       <= op[1] ? a_mag : b_mag;
            opnd_q    <= op[1] ? b_mag : a_mag;
            if (div_zero) begin
              hi          <= portA;
              lo          <= '1;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // WIDTH iteration cycles, then one cycle that publishes the result.
          if (count == LAST_CNT) begin
            hi          <= hi_f;
            lo          <= lo_f;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            acc_q <= acc_nx;
            q_q   <= q_nx;
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH = 32).
// A behavioural model (plain 64-bit arithmetic plus acceptance/latency
// bookkeeping) is compared against the DUT on every cycle; directed
// sequences pin the model with hand-computed results.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] portA, portB;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int cyc    = 0;  // index of the most recent rising edge
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .op          (op),
    .portA       (portA),
    .portB       (portB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Clock: edge counter advances just before each rising edge.
  initial forever begin
    #5 cyc++;
    CLK = 1'b1;
    #5 CLK = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} from plain wide arithmetic.
  function automatic logic [64:0] ref_result(input logic [1:0] f_op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [W-1:0]    rh, rl;
    logic            z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z  = 1'b0;
    rh = '0;
    rl = '0;
    case (f_op)
      2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      2'd2: begin
        if (b == '0) begin z = 1'b1; rh = a; rl = '1; end
        else begin
          sp = sa / sb; rl = sp[31:0];
          sp = sa % sb; rh = sp[31:0];
        end
      end
      default: begin
        if (b == '0) begin z = 1'b1; rh = a; rl = '1; end
        else begin
          up = ua / ub; rl = up[31:0];
          up = ua % ub; rh = up[31:0];
        end
      end
    endcase
    return {z, rh, rl};
  endfunction

  // Model: current operation (accept edge m_n, DONE edge m_d) and visible result.
  bit          m_pend = 1'b0;
  int          m_n = 0, m_d = 0;
  logic [64:0] m_res = '0;
  logic [64:0] v_res = '0;

  always @(posedge CLK or negedge nRST) begin : model
    bit in_calc;
    if (!nRST) begin
      m_pend = 1'b0;
      v_res  = '0;
    end else begin
      in_calc = m_pend && (cyc - 1 >= m_n) && (cyc - 1 < m_d);
      if (start && !in_calc) begin
        m_pend = 1'b1;
        m_n    = cyc;
        m_res  = ref_result(op, portA, portB);
        m_d    = (op[1] && portB == '0) ? cyc : cyc + W + 1;
      end
      if (m_pend && cyc == m_d) v_res = m_res;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin : compare
    bit e_busy, e_done;
    e_done = m_pend && (cyc == m_d);
    e_busy = m_pend && (cyc >= m_n) && (cyc < m_d);
    check("busy", 64'(busy), 64'(e_busy));
    check("done", 64'(done), 64'(e_done));
    check("div_by_zero", 64'(div_by_zero), 64'(v_res[64]));
    check("hi", 64'(hi), 64'(v_res[63:32]));
    check("lo", 64'(lo), 64'(v_res[31:0]));
  end

  int           acc_n;
  int           dones;
  logic [W-1:0] got_hi, got_lo;

  // Present one start pulse; returns at the first negedge after acceptance.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    start = 1'b1; op = o; portA = a; portB = b;
    @(negedge CLK);
    start = 1'b0;
    acc_n = cyc;
    op    = 2'($urandom);
    portA = $urandom;
    portB = $urandom;
  endtask

  // Bounded wait for done; a timeout shows up as a latency failure.
  task automatic wait_done(input string name, input int exp_lat);
    int i;
    i = 0;
    while (!done && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check({name, " latency"}, 64'(cyc - acc_n), 64'(exp_lat));
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] h, input logic [W-1:0] l,
                               input logic z);
    check({name, " hi"}, 64'(hi), 64'(h));
    check({name, " lo"}, 64'(lo), 64'(l));
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(z));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    nRST = 1'b0; start = 1'b0; op = '0; portA = '0; portB = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    expect_result("reset", 32'h0, 32'h0, 1'b0);
    nRST = 1'b1;

    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max", 33);
    expect_result("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    launch(2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done("mult -3*7", 33);
    expect_result("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    launch(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div -7/2", 33);
    expect_result("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1", 33);
    expect_result("div min/-1", 32'h0, 32'h8000_0000, 1'b0);

    // Divide by zero completes immediately; start in DONE runs back-to-back.
    launch(2'd3, 32'd100, 32'd0);
    wait_done("divu 100/0", 0);
    expect_result("divu 100/0", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    start = 1'b1; op = 2'd1; portA = 32'd2; portB = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    acc_n = cyc;
    check("back-to-back busy", 64'(busy), 64'(1));
    wait_done("multu 2*3", 33);
    expect_result("multu 2*3", 32'h0, 32'h6, 1'b0);

    // Start pulses during CALC are ignored.
    launch(2'd1, 32'd5, 32'd7);
    dones = 0; got_hi = '0; got_lo = '0;
    for (int i = 0; i < 45; i++) begin
      if (cyc - acc_n == 4 || cyc - acc_n == 9) begin
        start = 1'b1; op = 2'd3; portA = 32'd9; portB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      if (done) begin dones++; got_hi = hi; got_lo = lo; end
    end
    check("ignored start done count", 64'(dones), 64'(1));
    check("ignored start hi", 64'(got_hi), 64'(0));
    check("ignored start lo", 64'(got_lo), 64'(35));

    // Reset in CALC cycle 16 clears everything at once and drops the operation.
    launch(2'd3, 32'h55, 32'd0);
    wait_done("divu 0x55/0", 0);
    expect_result("divu 0x55/0", 32'h0000_0055, 32'hFFFF_FFFF, 1'b1);
    start = 1'b1; op = 2'd1; portA = 32'd7; portB = 32'd9;
    @(negedge CLK);
    start = 1'b0;
    acc_n = cyc;
    while (cyc - acc_n < 15) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("midcalc reset busy", 64'(busy), 64'(0));
    check("midcalc reset done", 64'(done), 64'(0));
    expect_result("midcalc reset", 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    nRST  = 1'b1;
    dones = 0;
    repeat (45) begin
      @(negedge CLK);
      if (done) dones++;
    end
    check("post reset done count", 64'(dones), 64'(0));

    // First edge after reset release accepts start.
    #2 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; start = 1'b1; op = 2'd1; portA = 32'd4; portB = 32'd5;
    @(negedge CLK);
    start = 1'b0;
    acc_n = cyc;
    check("first edge accept busy", 64'(busy), 64'(1));
    wait_done("multu 4*5", 33);
    expect_result("multu 4*5", 32'h0, 32'd20, 1'b0);

    // Random traffic: starts at any time, including during CALC and in DONE.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      portA = pick();
      portB = pick();
    end
    @(negedge CLK);
    start = 1'b0;
    repeat (40) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
